load_bus_master_mux: RTL
========================

Name: load_bus_master_mux

Overview:
- Datapath stage directly downstream of the load-bus arbiter.
- Consumes the one-hot grants m0_grnt..m2_grnt and forwards the granted master's AXI read-address (AR) request onto the single shared slave port.
- Locks ownership for the full burst and steers read-data (R) beats back to the owning master until RLAST.
- Required because arbiter grants may move every cycle; this block makes a transaction atomic.

Parameters:
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- m0_grnt, m1_grnt, m2_grnt  in  1 each  grants from the arbiter, one-hot, owner encoding 00/01/10
- mX_araddr  in  ADDR_W  per master X=0..2, AR address
- mX_arlen  in  8  per master, beats-1
- mX_arsize  in  3  per master
- mX_arburst  in  2  per master
- mX_arvalid  in  1  per master
- mX_arready  out  1  per master
- mX_rdata  out  DATA_W  per master
- mX_rlast  out  1  per master
- mX_rvalid  out  1  per master
- mX_rready  in  1  per master
- s_araddr / s_arlen / s_arsize / s_arburst  out  ADDR_W/8/3/2  registered AR payload to slave
- s_arvalid  out  1
- s_arready  in  1
- s_rdata  in  DATA_W
- s_rlast  in  1
- s_rvalid  in  1
- s_rready  out  1
- busy  out  1  high while a transaction is owned (state != IDLE)
- rlast_err  out  1  one-cycle pulse on burst-length mismatch

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: owner[1:0], AR payload, latched arlen, beat_cnt[7:0].
- Reset: state=IDLE; owner=00; beat_cnt=0. All of the following read 0: s_ar* payload, s_arvalid, busy, rlast_err, all mX_arready, all mX_rvalid, all mX_rlast, s_rready.
- IDLE to ADDR:
  - Transition when exactly one grant is high and that master's arvalid=1.
  - Same cycle: that master's arready=1 (combinational) and the payload is captured.
  - Next cycle: s_arvalid=1. Latency from arvalid to s_arvalid is 1 cycle.
  - No grant, more than one grant, or a granted master with arvalid=0: stay IDLE, all arready=0.
- ADDR:
  - s_arvalid held at 1 with payload stable until s_arready=1.
  - Transition to DATA on the cycle after the handshake; beat_cnt=0.
- DATA:
  - Combinational routing to the owner: s_rready = m[owner]_rready; m[owner]_rvalid = s_rvalid; m[owner]_rlast = s_rlast.
  - rdata fans out to all masters; non-owners have rvalid=0.
  - Each beat (s_rvalid & s_rready) increments beat_cnt.
  - Beat with s_rlast=1: go to IDLE next cycle.
  - rlast_err pulses when s_rlast arrives with beat_cnt != latched arlen.
  - rlast_err also pulses (once) when beat_cnt would exceed arlen without s_rlast.
  - Completion is always governed by s_rlast, never by the count.
- Grants changing in ADDR/DATA are ignored; the latched owner persists until return to IDLE.
- A new AR is never accepted in the same cycle the last R beat completes (minimum 1 IDLE cycle between bursts).
- Reset asserted mid-ADDR or mid-DATA: next edge forces all reset values. The outstanding burst is abandoned; slave reset is a system-level concern.
- beat_cnt saturates at 255 (arlen=255 means 256 beats; wrap is not allowed).

Decomposition:
- Shared package load_bus_pkg holds:
  - owner encodings OWN_M0=2'b00, OWN_M1=2'b01, OWN_M2=2'b10 (identical to the arbiter's)
  - FSM state encodings
  - AXI burst constants (FIXED/INCR/WRAP)
- One sub-module is natural: load_bus_r_router, the purely combinational R-channel steering keyed by owner. The FSM, payload registers and counter stay in the top.

Test Plan:
- m1_grnt=1, m1_arvalid=1, araddr=0x1000_0040, arlen=3, s_arready tied 1 -> m1_arready pulses 1 cycle; s_arvalid=1 with araddr 0x1000_0040 the next cycle; 4 R beats reach only m1; rlast on beat 4; busy falls 1 cycle later.
- During the test-1 DATA phase, switch grant to m0 with m0_arvalid=1 -> m0_arready stays 0 and R stays routed to m1 until rlast; m0 is accepted on the first IDLE cycle afterwards.
- s_arready held 0 for 5 cycles -> s_arvalid and payload stable for all 5 cycles; transition to DATA only after the handshake.
- m2 owner with arlen=1, rready toggled 1,0,1 -> s_rready mirrors m2_rready; exactly 2 beats counted; rlast_err stays 0.
- arlen=3 but slave asserts rlast on beat 2 -> rlast_err pulses 1 cycle on that beat; FSM returns to IDLE.
- rst=1 asserted in DATA after beat 1 -> next cycle busy=0, state IDLE, all rvalid/arready 0, owner=00.

Source files
------------

// File: rtl/load_bus_master_mux_pkg.sv
// Shared constants for the load-bus datapath: owner codes, FSM states, AXI burst types.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Owner codes are identical to the arbiter's, so an owner value can be
// compared directly against arbiter-side state.
package load_bus_pkg;

  localparam logic [1:0] OWN_M0 = 2'b00;
  localparam logic [1:0] OWN_M1 = 2'b01;
  localparam logic [1:0] OWN_M2 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/load_bus_master_mux_if.sv
// AXI read channel (AR + R) between one requester and one responder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both AR and R.
//
// master modport: drives AR and rready (the requester side).
// slave modport : drives arready and the R beat (the responder side).
interface load_bus_master_mux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rlast, rvalid
  );

endinterface

// File: rtl/load_bus_master_mux_r_router.sv
// R-channel steering: routes slave read beats to the owning master.
// Latency: 0 cycles, purely combinational.
// Backpressure: s_rready mirrors the owner's rready; non-owners see rvalid=0.
//
// Ports: active (high only while a burst is in its data phase), owner code,
// slave R beat in, per-master rready in; per-master rvalid/rlast out,
// fanned-out rdata, s_rready out.
module load_bus_r_router
  import load_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              active,
  input  logic [1:0]        owner,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [2:0]        m_rready,
  output logic [2:0]        m_rvalid,
  output logic [2:0]        m_rlast,
  output logic [DATA_W-1:0] m_rdata
);

  // Data is shared by all masters; only the qualifying rvalid is steered.
  assign m_rdata = s_rdata;

  always_comb begin
    s_rready = 1'b0;
    m_rvalid = 3'b000;
    m_rlast  = 3'b000;
    if (active) begin
      case (owner)
        OWN_M0: begin
          s_rready    = m_rready[0];
          m_rvalid[0] = s_rvalid;
          m_rlast[0]  = s_rlast;
        end
        OWN_M1: begin
          s_rready    = m_rready[1];
          m_rvalid[1] = s_rvalid;
          m_rlast[1]  = s_rlast;
        end
        OWN_M2: begin
          s_rready    = m_rready[2];
          m_rvalid[2] = s_rvalid;
          m_rlast[2]  = s_rlast;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/load_bus_master_mux.sv
// Locks the granted master onto the shared slave port for one whole AXI read burst.
// Latency: arvalid -> s_arvalid 1 cycle; R beats routed combinationally.
// Backpressure: s_arvalid held until s_arready; R stalls follow the owner's rready.
//
// Ports: clk, rst (sync, active high); m0..m2_grnt one-hot arbiter grants;
// m0..m2 master-facing read channels; s slave-facing read channel;
// busy (burst owned), rlast_err (one-cycle pulse on burst-length mismatch).
module load_bus_master_mux
  import load_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_grnt,
  input  logic                  m1_grnt,
  input  logic                  m2_grnt,
  load_bus_master_mux_if.slave  m0,
  load_bus_master_mux_if.slave  m1,
  load_bus_master_mux_if.slave  m2,
  load_bus_master_mux_if.master s,
  output logic                  busy,
  output logic                  rlast_err
);

  state_t            state;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic              arvalid_q;
  logic [7:0]        beat_cnt;
  logic              ovf_flagged;

  logic [1:0]        sel_owner;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;
  logic              accept;

  logic              s_rready_int;
  logic [2:0]        r_vld;
  logic [2:0]        r_last;
  logic [DATA_W-1:0] r_dat;
  logic              beat;

  // Only a clean one-hot grant selects a request; zero or multiple grants select nothing.
  always_comb begin
    sel_owner = OWN_M0;
    sel_vld   = 1'b0;
    sel_addr  = m0.araddr;
    sel_len   = m0.arlen;
    sel_size  = m0.arsize;
    sel_burst = m0.arburst;
    case ({m2_grnt, m1_grnt, m0_grnt})
      3'b001: sel_vld = m0.arvalid;
      3'b010: begin
        sel_owner = OWN_M1;
        sel_vld   = m1.arvalid;
        sel_addr  = m1.araddr;
        sel_len   = m1.arlen;
        sel_size  = m1.arsize;
        sel_burst = m1.arburst;
      end
      3'b100: begin
        sel_owner = OWN_M2;
        sel_vld   = m2.arvalid;
        sel_addr  = m2.araddr;
        sel_len   = m2.arlen;
        sel_size  = m2.arsize;
        sel_burst = m2.arburst;
      end
      default: ;
    endcase
  end

  // Requests are taken only from IDLE, so a new burst can never start in the
  // cycle the previous one completes.
  assign accept     = !rst && (state == ST_IDLE) && sel_vld;
  assign m0.arready = accept && (sel_owner == OWN_M0);
  assign m1.arready = accept && (sel_owner == OWN_M1);
  assign m2.arready = accept && (sel_owner == OWN_M2);

  assign s.araddr  = araddr_q;
  assign s.arlen   = arlen_q;
  assign s.arsize  = arsize_q;
  assign s.arburst = arburst_q;
  assign s.arvalid = arvalid_q;
  assign busy      = (state != ST_IDLE);

  load_bus_r_router #(.DATA_W(DATA_W)) u_r_router (
    .active   (state == ST_DATA),
    .owner    (owner),
    .s_rdata  (s.rdata),
    .s_rlast  (s.rlast),
    .s_rvalid (s.rvalid),
    .s_rready (s_rready_int),
    .m_rready ({m2.rready, m1.rready, m0.rready}),
    .m_rvalid (r_vld),
    .m_rlast  (r_last),
    .m_rdata  (r_dat)
  );

  assign s.rready  = s_rready_int;
  assign m0.rvalid = r_vld[0];
  assign m1.rvalid = r_vld[1];
  assign m2.rvalid = r_vld[2];
  assign m0.rlast  = r_last[0];
  assign m1.rlast  = r_last[1];
  assign m2.rlast  = r_last[2];
  assign m0.rdata  = r_dat;
  assign m1.rdata  = r_dat;
  assign m2.rdata  = r_dat;

  assign beat = (state == ST_DATA) && s.rvalid && s_rready_int;

  // beat_cnt holds the number of beats already accepted, so the beat carrying
  // rlast must see beat_cnt == arlen. A non-last beat at that count would push
  // past arlen; that overrun is reported once per burst.
  assign rlast_err = !rst && beat &&
                     (s.rlast ? (beat_cnt != arlen_q)
                              : ((beat_cnt == arlen_q) && !ovf_flagged));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_M0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      arvalid_q   <= 1'b0;
      beat_cnt    <= '0;
      ovf_flagged <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner     <= sel_owner;
            araddr_q  <= sel_addr;
            arlen_q   <= sel_len;
            arsize_q  <= sel_size;
            arburst_q <= sel_burst;
            arvalid_q <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s.arready) begin
            arvalid_q   <= 1'b0;
            beat_cnt    <= '0;
            ovf_flagged <= 1'b0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
            if (!s.rlast && (beat_cnt == arlen_q)) ovf_flagged <= 1'b1;
            // Completion follows s_rlast only, whatever the count says.
            if (s.rlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
